// File: rtl/id_ex_operand_stage_if.sv
// Bus bundle for the ID/EX operand stage: decode bundle in, EX/MEM and MEM/WB
// bypass sources in, ALU operands and registered controls out.
interface id_ex_operand_stage_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RAW  = 5
);
  // decode bundle
  logic            id_valid;
  logic [RAW-1:0]  id_rs1;
  logic [RAW-1:0]  id_rs2;
  logic            id_use_rs1;
  logic            id_use_rs2;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [XLEN-1:0] id_imm;
  logic            id_alu_src;
  logic [3:0]      id_alu_ctrl;
  logic [RAW-1:0]  id_rd;
  logic            id_reg_write;
  logic            id_mem_read;
  logic            id_mem_write;

  // downstream bypass sources
  logic [RAW-1:0]  mem_rd;
  logic            mem_reg_write;
  logic [XLEN-1:0] mem_result;
  logic [RAW-1:0]  wb_rd;
  logic            wb_reg_write;
  logic [XLEN-1:0] wb_result;

  // pipeline control
  logic            ex_hold;
  logic            flush;

  // stage outputs
  logic            hazard_stall;
  logic            ex_valid;
  logic [XLEN-1:0] alu_in_1;
  logic [XLEN-1:0] alu_in_2;
  logic [3:0]      alu_ctrl;
  logic [XLEN-1:0] store_data;
  logic [RAW-1:0]  ex_rd;
  logic            ex_reg_write;
  logic            ex_mem_read;
  logic            ex_mem_write;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rs1_data, id_rs2_data,
           id_imm, id_alu_src, id_alu_ctrl, id_rd, id_reg_write, id_mem_read, id_mem_write,
           mem_rd, mem_reg_write, mem_result, wb_rd, wb_reg_write, wb_result,
           ex_hold, flush,
    input  hazard_stall, ex_valid, alu_in_1, alu_in_2, alu_ctrl, store_data,
           ex_rd, ex_reg_write, ex_mem_read, ex_mem_write
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rs1_data, id_rs2_data,
           id_imm, id_alu_src, id_alu_ctrl, id_rd, id_reg_write, id_mem_read, id_mem_write,
           mem_rd, mem_reg_write, mem_result, wb_rd, wb_reg_write, wb_result,
           ex_hold, flush,
    output hazard_stall, ex_valid, alu_in_1, alu_in_2, alu_ctrl, store_data,
           ex_rd, ex_reg_write, ex_mem_read, ex_mem_write
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register feeding the ALU. Captures the decode bundle, inserts
// bubbles on load-use hazards, honours hold/flush and presents bypassed operands.
// Build option FORWARDING_EN: when defined, operands are bypassed from EX/MEM
// (priority) and MEM/WB; when undefined, operands come straight from the
// regfile and any RAW dependency on EX or MEM stalls decode instead.
module id_ex_operand_stage #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RAW  = 5
) (
  input logic             clk,
  input logic             rst,
  id_ex_operand_stage_if.slave bus
);

  typedef struct packed {
    logic            valid;
    logic [RAW-1:0]  rs1;
    logic [RAW-1:0]  rs2;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic            alu_src;
    logic [3:0]      alu_ctrl;
    logic [RAW-1:0]  rd;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
  } ex_bundle_t;

  ex_bundle_t      ex_q;
  ex_bundle_t      ex_d;
  ex_bundle_t      load_b;
  logic            hazard;
  logic            load_use;
  logic            id_hits_ex;
  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;

  // Does the decoding instruction read the register EX is about to write?
  always_comb begin
    id_hits_ex = (bus.id_use_rs1 && (bus.id_rs1 == ex_q.rd)) ||
                 (bus.id_use_rs2 && (bus.id_rs2 == ex_q.rd));
  end

  // Load-use detection: load data is not available until after MEM.
  always_comb begin
    load_use = bus.id_valid && ex_q.valid && ex_q.mem_read &&
               (ex_q.rd != '0) && id_hits_ex;
  end

`ifdef FORWARDING_EN
  // Only load-use needs a bubble; everything else is bypassed.
  always_comb begin
    hazard = !rst && load_use;
  end

  // Operand bypass: EX/MEM wins over MEM/WB, x0 and empty slots never bypass.
  always_comb begin
    fwd_rs1 = ex_q.rs1_data;
    fwd_rs2 = ex_q.rs2_data;
    if (ex_q.valid && (ex_q.rs1 != '0)) begin
      if (bus.mem_reg_write && (bus.mem_rd == ex_q.rs1)) begin
        fwd_rs1 = bus.mem_result;
      end else if (bus.wb_reg_write && (bus.wb_rd == ex_q.rs1)) begin
        fwd_rs1 = bus.wb_result;
      end
    end
    if (ex_q.valid && (ex_q.rs2 != '0)) begin
      if (bus.mem_reg_write && (bus.mem_rd == ex_q.rs2)) begin
        fwd_rs2 = bus.mem_result;
      end else if (bus.wb_reg_write && (bus.wb_rd == ex_q.rs2)) begin
        fwd_rs2 = bus.wb_result;
      end
    end
  end
`else
  logic ex_raw;
  logic mem_raw;
  logic unused_fwd_sources;

  // Without bypass, any pending write in EX or MEM to a source stalls decode;
  // the MEM/WB case is covered by the write-first regfile.
  always_comb begin
    ex_raw  = bus.id_valid && ex_q.valid && ex_q.reg_write &&
              (ex_q.rd != '0) && id_hits_ex;
    mem_raw = bus.id_valid && bus.mem_reg_write && (bus.mem_rd != '0) &&
              ((bus.id_use_rs1 && (bus.id_rs1 == bus.mem_rd)) ||
               (bus.id_use_rs2 && (bus.id_rs2 == bus.mem_rd)));
    hazard  = !rst && (load_use || ex_raw || mem_raw);
  end

  // Operands are the registered regfile data as-is.
  always_comb begin
    fwd_rs1 = ex_q.rs1_data;
    fwd_rs2 = ex_q.rs2_data;
  end

  assign unused_fwd_sources = ^{bus.mem_result, bus.wb_rd, bus.wb_reg_write,
                                bus.wb_result, ex_q.rs1, ex_q.rs2};
`endif

  // Bundle captured on a normal load; invalid slots carry no side effects.
  always_comb begin
    load_b           = '0;
    load_b.valid     = bus.id_valid;
    load_b.rs1       = bus.id_rs1;
    load_b.rs2       = bus.id_rs2;
    load_b.rs1_data  = bus.id_rs1_data;
    load_b.rs2_data  = bus.id_rs2_data;
    load_b.imm       = bus.id_imm;
    load_b.alu_src   = bus.id_alu_src;
    load_b.alu_ctrl  = bus.id_valid ? bus.id_alu_ctrl : 4'b0000;
    load_b.rd        = bus.id_valid ? bus.id_rd : '0;
    load_b.reg_write = bus.id_valid && bus.id_reg_write;
    load_b.mem_read  = bus.id_valid && bus.id_mem_read;
    load_b.mem_write = bus.id_valid && bus.id_mem_write;
  end

  // Next-state priority: flush > hold > hazard bubble > load.
  always_comb begin
    ex_d = ex_q;
    if (bus.flush) begin
      ex_d = '0;
    end else if (bus.ex_hold) begin
      ex_d = ex_q;
    end else if (hazard) begin
      ex_d = '0;
    end else begin
      ex_d = load_b;
    end
  end

  // Stage register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign bus.hazard_stall = hazard;
  assign bus.ex_valid     = ex_q.valid;
  assign bus.alu_in_1     = fwd_rs1;
  assign bus.alu_in_2     = ex_q.alu_src ? ex_q.imm : fwd_rs2;
  assign bus.alu_ctrl     = ex_q.alu_ctrl;
  assign bus.store_data   = fwd_rs2;
  assign bus.ex_rd        = ex_q.rd;
  assign bus.ex_reg_write = ex_q.reg_write;
  assign bus.ex_mem_read  = ex_q.mem_read;
  assign bus.ex_mem_write = ex_q.mem_write;

endmodule
